bubble_sort_ctrl: RTL and testbench

//  Initiator side of the ALU compare interface: FSM that bubble-sorts DEPTH unsigned words in place.

---
 rtl/bubble_sort_ctrl_if.sv | 38 +++
 rtl/bubble_sort_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bubble_sort_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sort_ctrl_if
// Purpose  : Bundles the sorter's start/status, RAM and ALU compare signals.
// Revision : 1.0
// ============================================================================
interface bubble_sort_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_we;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic              alu_operation;
    logic              alu_lt;
    logic [DATA_W-1:0] alu_result;

    // Controller side: drives RAM/ALU requests and status.
    modport master (
        input  start, mem_rd_data, alu_lt, alu_result,
        output busy, done, mem_addr, mem_wr_data, mem_we,
               alu_op1, alu_op2, alu_operation
    );

    // Environment side: wrapper, RAM and ALU.
    modport slave (
        output start, mem_rd_data, alu_lt, alu_result,
        input  busy, done, mem_addr, mem_wr_data, mem_we,
               alu_op1, alu_op2, alu_operation
    );
endinterface
`default_nettype wire

// File: rtl/bubble_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sort_ctrl
// Purpose  : Bubble-sorts DEPTH unsigned words in a sync single-port RAM,
//            using the shared ALU's strict less-than for each compare.
// Options  : BUBBLE_EARLY_EXIT_EN - stop after the first pass with no swap.
// Revision : 1.0
// ============================================================================
module bubble_sort_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  wire                 clk,
    input  wire                 rst_n,
    bubble_sort_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_LATCH = 3'd3,
        S_EVAL  = 3'd4,
        S_WR_A  = 3'd5,
        S_WR_B  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Index of the last pass; also the upper bound of j on pass 0.
    localparam int c_LAST = DEPTH - 2;

`ifdef BUBBLE_EARLY_EXIT_EN
    localparam bit c_EARLY_EXIT = 1'b1;
`else
    localparam bit c_EARLY_EXIT = 1'b0;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_j;
    logic [ADDR_W-1:0]  w_j_nxt;
    logic [ADDR_W-1:0]  r_pass;
    logic [ADDR_W-1:0]  w_pass_nxt;
    logic               r_swapped;
    logic               w_swapped_nxt;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  w_a_nxt;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  w_b_nxt;

    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_wr_data;
    logic               w_mem_we;
    logic               w_alu_operation;
    logic               w_advance;
    logic               w_j_at_bound;
    logic               w_pass_last;
    logic               w_exit;

    // The compare window shrinks by one word per completed pass.
    assign w_j_at_bound = (int'(r_j) >= (c_LAST - int'(r_pass)));
    assign w_pass_last  = (int'(r_pass) >= c_LAST);
    assign w_exit       = w_pass_last || (c_EARLY_EXIT && !r_swapped);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j       <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
        end else begin
            r_j       <= w_j_nxt;
            r_pass    <= w_pass_nxt;
            r_swapped <= w_swapped_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_j_nxt         = r_j;
        w_pass_nxt      = r_pass;
        w_swapped_nxt   = r_swapped;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_mem_addr      = '0;
        w_mem_wr_data   = '0;
        w_mem_we        = 1'b0;
        w_alu_operation = 1'b0;
        w_advance       = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_j_nxt       = '0;
                    w_pass_nxt    = '0;
                    w_swapped_nxt = 1'b0;
                    w_state_nxt   = (DEPTH == 1) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                w_mem_addr  = r_j;
                w_state_nxt = S_RD_B;
            end
            S_RD_B: begin
                // Read data returning now belongs to the address issued in RD_A.
                w_mem_addr  = r_j + 1'b1;
                w_a_nxt     = bus.mem_rd_data;
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_b_nxt     = bus.mem_rd_data;
                w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                w_alu_operation = 1'b1;
                if (bus.alu_lt) begin
                    w_swapped_nxt = 1'b1;
                    w_state_nxt   = S_WR_A;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_WR_A: begin
                w_mem_addr    = r_j;
                w_mem_wr_data = r_b;
                w_mem_we      = 1'b1;
                w_state_nxt   = S_WR_B;
            end
            S_WR_B: begin
                w_mem_addr    = r_j + 1'b1;
                w_mem_wr_data = r_a;
                w_mem_we      = 1'b1;
                w_advance     = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_advance) begin
            if (!w_j_at_bound) begin
                w_j_nxt     = r_j + 1'b1;
                w_state_nxt = S_RD_A;
            end else if (w_exit) begin
                w_state_nxt = S_DONE;
            end else begin
                w_pass_nxt    = r_pass + 1'b1;
                w_j_nxt       = '0;
                w_swapped_nxt = 1'b0;
                w_state_nxt   = S_RD_A;
            end
        end
    end

    assign bus.busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done          = (r_state == S_DONE);
    assign bus.mem_addr      = w_mem_addr;
    assign bus.mem_wr_data   = w_mem_wr_data;
    assign bus.mem_we        = w_mem_we;
    assign bus.alu_op1       = r_b;
    assign bus.alu_op2       = r_a;
    assign bus.alu_operation = w_alu_operation;

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bubble_sort_ctrl
// Purpose  : Scoreboard bench for bubble_sort_ctrl (DEPTH 8, 2 and 1 instances).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bubble_sort_ctrl;

    typedef struct packed {
        int               lat;
        int               wr;
        logic [7:0][15:0] ram;
    } exp_t;

`ifdef BUBBLE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bubble_sort_ctrl_if #(.DATA_W(16), .ADDR_W(3)) b8 ();
    bubble_sort_ctrl_if #(.DATA_W(16), .ADDR_W(1)) b2 ();
    bubble_sort_ctrl_if #(.DATA_W(16), .ADDR_W(1)) b1 ();

    bubble_sort_ctrl #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.master));
    bubble_sort_ctrl #(.DATA_W(16), .DEPTH(2), .ADDR_W(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.master));
    bubble_sort_ctrl #(.DATA_W(16), .DEPTH(1), .ADDR_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    // RAM + ALU models, one per instance; ld_* is a whole-array backdoor load.
    logic [7:0][15:0] ram8, ld8;
    logic [1:0][15:0] ram2, ld2, ram1, ld1;
    logic ld8_en, ld2_en, ld1_en;
    int   wr8 = 0, wr2 = 0, wr1 = 0;
    int   t8 = 0, t2 = 0, t1 = 0;
    exp_t q8[$], q2[$], q1[$];

    always @(posedge clk) begin
        if (ld8_en) begin ram8 <= ld8; wr8 <= 0; end
        else if (b8.mem_we) begin ram8[b8.mem_addr] <= b8.mem_wr_data; wr8 <= wr8 + 1; end
        b8.mem_rd_data <= ram8[b8.mem_addr];
    end
    always @(posedge clk) begin
        if (ld2_en) begin ram2 <= ld2; wr2 <= 0; end
        else if (b2.mem_we) begin ram2[b2.mem_addr] <= b2.mem_wr_data; wr2 <= wr2 + 1; end
        b2.mem_rd_data <= ram2[b2.mem_addr];
    end
    always @(posedge clk) begin
        if (ld1_en) begin ram1 <= ld1; wr1 <= 0; end
        else if (b1.mem_we) begin ram1[b1.mem_addr] <= b1.mem_wr_data; wr1 <= wr1 + 1; end
        b1.mem_rd_data <= ram1[b1.mem_addr];
    end

    assign b8.alu_lt     = b8.alu_operation && (b8.alu_op1 < b8.alu_op2);
    assign b8.alu_result = b8.alu_op1 - b8.alu_op2;
    assign b2.alu_lt     = b2.alu_operation && (b2.alu_op1 < b2.alu_op2);
    assign b2.alu_result = b2.alu_op1 - b2.alu_op2;
    assign b1.alu_lt     = b1.alu_operation && (b1.alu_op1 < b1.alu_op2);
    assign b1.alu_result = b1.alu_op1 - b1.alu_op2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event, required normal completion", name);
    endtask

    task automatic score(input string tag, input exp_t e, input int lat, input int wr,
                         input logic [7:0][15:0] ram, input int n);
        check({tag, " latency"}, lat, e.lat);
        check({tag, " writes"}, wr, e.wr);
        for (int i = 0; i < n; i++)
            check($sformatf("%s ram[%0d]", tag, i), {16'h0, ram[i]}, {16'h0, e.ram[i]});
    endtask

    function automatic logic [7:0][15:0] v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic exp_t mk(input int lat, input int wr, input logic [7:0][15:0] ram);
        exp_t e;
        e.lat = lat;
        e.wr  = wr;
        e.ram = ram;
        return e;
    endfunction

    // Monitors: on each rising done, pop the expectation and compare.
    logic d8_q, d2_q, d1_q;
    always @(negedge clk) begin
        d8_q <= b8.done;
        if (rst_n && b8.done && !d8_q) begin
            if (q8.size() == 0) fail("dut8 unexpected done");
            else score("dut8", q8.pop_front(), cyc - t8 + 1, wr8, ram8, 8);
        end
    end
    always @(negedge clk) begin
        d2_q <= b2.done;
        if (rst_n && b2.done && !d2_q) begin
            if (q2.size() == 0) fail("dut2 unexpected done");
            else score("dut2", q2.pop_front(), cyc - t2 + 1, wr2, {96'h0, ram2}, 2);
        end
    end
    always @(negedge clk) begin
        d1_q <= b1.done;
        if (rst_n && b1.done && !d1_q) begin
            if (q1.size() == 0) fail("dut1 unexpected done");
            else score("dut1", q1.pop_front(), cyc - t1 + 1, wr1, {96'h0, ram1}, 1);
        end
    end

    task automatic load8(input logic [7:0][15:0] init);
        @(negedge clk);
        ld8    = init;
        ld8_en = 1'b1;
        @(negedge clk);
        ld8_en = 1'b0;
    endtask

    task automatic run8(input string tag, input logic [7:0][15:0] init, input exp_t e, input bit poke);
        bit got;
        got = 1'b0;
        load8(init);
        q8.push_back(e);
        b8.start = 1'b1;
        t8       = cyc + 1;
        @(negedge clk);
        b8.start = 1'b0;
        check({tag, " busy after start"}, b8.busy, 1);
        check({tag, " done cleared"}, b8.done, 0);
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            b8.start = poke && (k == 10);
            got      = b8.done;
        end
        b8.start = 1'b0;
        if (!got) fail({tag, " done wait"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        b8.start = 1'b0; b2.start = 1'b0; b1.start = 1'b0;
        ld8_en = 1'b0; ld2_en = 1'b0; ld1_en = 1'b0;
        ld8 = '0; ld2 = '0; ld1 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", b8.busy, 0);
        check("reset done", b8.done, 0);
        check("reset mem_we", b8.mem_we, 0);
        check("reset alu_operation", b8.alu_operation, 0);
        check("reset mem_addr", b8.mem_addr, 0);

        // Asynchronous reset while a compare is in flight.
        load8(v8(7, 6, 5, 4, 3, 2, 1, 0));
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = b8.alu_operation;
        end
        if (!got) fail("wait for EVAL");
        check("pre-reset alu_op1", b8.alu_op1, 6);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", b8.busy, 0);
        check("async rst done", b8.done, 0);
        check("async rst mem_we", b8.mem_we, 0);
        check("async rst alu_operation", b8.alu_operation, 0);
        check("async rst alu_op1", b8.alu_op1, 0);
        check("async rst alu_op2", b8.alu_op2, 0);
        check("async rst mem_addr", b8.mem_addr, 0);
        @(negedge clk);
        check("rst held mem_we", b8.mem_we, 0);
        rst_n = 1'b1;

        run8("ascending", v8(0, 1, 2, 3, 4, 5, 6, 7),
             mk(EE ? 29 : 113, 0, v8(0, 1, 2, 3, 4, 5, 6, 7)), 1'b0);
        run8("descending", v8(7, 6, 5, 4, 3, 2, 1, 0),
             mk(169, 56, v8(0, 1, 2, 3, 4, 5, 6, 7)), 1'b0);
        repeat (5) @(negedge clk);
        check("done level holds", b8.done, 1);
        check("busy low in done", b8.busy, 0);
        run8("equal", v8(5, 5, 5, 5, 5, 5, 5, 5),
             mk(EE ? 29 : 113, 0, v8(5, 5, 5, 5, 5, 5, 5, 5)), 1'b0);
        run8("unsigned", v8('hFFFF, 1, 'h8000, 0, 'h7FFF, 2, 'h8001, 3),
             mk(EE ? 131 : 143, 30, v8(0, 1, 2, 3, 'h7FFF, 'h8000, 'h8001, 'hFFFF)), 1'b1);

        // Two-word sort: one compare with a swap.
        @(negedge clk);
        ld2 = {16'd3, 16'd9};
        ld2_en = 1'b1;
        @(negedge clk);
        ld2_en = 1'b0;
        q2.push_back(mk(7, 2, {96'h0, 16'd9, 16'd3}));
        b2.start = 1'b1;
        t2 = cyc + 1;
        @(negedge clk);
        b2.start = 1'b0;

        // Single word: nothing to compare, done right after start.
        ld1 = {16'h0, 16'h1234};
        ld1_en = 1'b1;
        @(negedge clk);
        ld1_en = 1'b0;
        q1.push_back(mk(1, 0, {112'h0, 16'h1234}));
        b1.start = 1'b1;
        t1 = cyc + 1;
        @(negedge clk);
        b1.start = 1'b0;

        repeat (12) @(negedge clk);
        check("dut2 done level", b2.done, 1);
        check("dut1 done level", b1.done, 1);
        check("dut8 queue drained", q8.size(), 0);
        check("dut2 queue drained", q2.size(), 0);
        check("dut1 queue drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
